// File: rtl/aes_stream_arbiter.sv
// aes_stream_arbiter
//   Packet-granular arbiter sharing one AES controller between two
//   AXI-Stream requesters. A whole request packet (up to tlast) is forwarded
//   atomically from the granted requester to the controller. The requester
//   index of every granted packet is queued in an in-order tag FIFO, and each
//   response packet from the controller is steered to the requester at the
//   head of that FIFO.
//
// Parameters
//   DATA_WIDTH  width of every tdata bus
//   TAG_DEPTH   max request packets awaiting a response (power of two, >= 2)
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   s0_*, s1_*             request streams from requester 0 / 1 (slave side)
//   m_*                    request stream to the AES controller
//   r_*                    response stream from the AES controller
//   d0_*, d1_*             response streams to requester 0 / 1
//   grant                  one-hot current request grant, 2'b00 when idle
//   outstanding            tag FIFO occupancy
//
// Configuration
//   AES_ARB_ROUND_ROBIN_EN  defined: round-robin between contending
//                           requesters (s0 wins the first contention);
//                           undefined: fixed priority, s0 always wins.

module aes_stream_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         resetn,

   input  logic                         s0_tvalid,
   output logic                         s0_tready,
   input  logic [DATA_WIDTH-1:0]        s0_tdata,
   input  logic                         s0_tlast,

   input  logic                         s1_tvalid,
   output logic                         s1_tready,
   input  logic [DATA_WIDTH-1:0]        s1_tdata,
   input  logic                         s1_tlast,

   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DATA_WIDTH-1:0]        m_tdata,
   output logic                         m_tlast,

   input  logic                         r_tvalid,
   output logic                         r_tready,
   input  logic [DATA_WIDTH-1:0]        r_tdata,
   input  logic                         r_tlast,

   output logic                         d0_tvalid,
   input  logic                         d0_tready,
   output logic [DATA_WIDTH-1:0]        d0_tdata,
   output logic                         d0_tlast,

   output logic                         d1_tvalid,
   input  logic                         d1_tready,
   output logic [DATA_WIDTH-1:0]        d1_tdata,
   output logic                         d1_tlast,

   output logic [1:0]                   grant,
   output logic [$clog2(TAG_DEPTH):0]   outstanding
);

   localparam int unsigned PTR_W = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;

   // Tag FIFO: pointers carry one extra wrap bit so full and empty differ.
   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic [TAG_DEPTH-1:0] tag_mem;
   logic [PTR_W:0]       count;
   logic                 full;
   logic                 empty;
   logic                 head;

   logic                 push;
   logic                 push_tag;
   logic                 pop;
   logic                 pick1;

   assign count       = wr_ptr - rd_ptr;
   assign full        = (count == (PTR_W+1)'(TAG_DEPTH));
   assign empty       = (count == '0);
   assign head        = tag_mem[rd_ptr[PTR_W-1:0]];
   assign outstanding = count;

`ifdef AES_ARB_ROUND_ROBIN_EN
   // Index of the requester granted most recently; 1 after reset so that
   // s0 wins the first contention.
   logic last_served;

   assign pick1 = s1_tvalid & (~s0_tvalid | ~last_served);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_served <= 1'b1;
      end else if (push) begin
         last_served <= push_tag;
      end
   end
`else
   assign pick1 = s1_tvalid & ~s0_tvalid;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and request-side outputs. The grant decision is taken in
   // IDLE and registered, so the first beat moves one cycle later; the tag
   // is pushed on that same transition edge.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_tag  = 1'b0;
      grant     = 2'b00;
      m_tvalid  = 1'b0;
      m_tdata   = '0;
      m_tlast   = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;

      case (state)
         IDLE: begin
            if (!full && (s0_tvalid || s1_tvalid)) begin
               push      = 1'b1;
               push_tag  = pick1;
               state_nxt = pick1 ? GNT1 : GNT0;
            end
         end
         GNT0: begin
            grant     = 2'b01;
            m_tvalid  = s0_tvalid;
            m_tdata   = s0_tdata;
            m_tlast   = s0_tlast;
            s0_tready = m_tready;
            if (s0_tvalid && m_tready && s0_tlast) begin
               state_nxt = IDLE;
            end
         end
         GNT1: begin
            grant     = 2'b10;
            m_tvalid  = s1_tvalid;
            m_tdata   = s1_tdata;
            m_tlast   = s1_tlast;
            s1_tready = m_tready;
            if (s1_tvalid && m_tready && s1_tlast) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Response demux: the head tag selects the destination. With no tag
   // queued the controller is never accepted from, so nothing can leak out.
   always_comb begin
      r_tready  = 1'b0;
      d0_tvalid = 1'b0;
      d0_tdata  = '0;
      d0_tlast  = 1'b0;
      d1_tvalid = 1'b0;
      d1_tdata  = '0;
      d1_tlast  = 1'b0;

      if (!empty) begin
         if (!head) begin
            d0_tvalid = r_tvalid;
            d0_tdata  = r_tdata;
            d0_tlast  = r_tlast;
            r_tready  = d0_tready;
         end else begin
            d1_tvalid = r_tvalid;
            d1_tdata  = r_tdata;
            d1_tlast  = r_tlast;
            r_tready  = d1_tready;
         end
      end
   end

   assign pop = r_tvalid & r_tready & r_tlast;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_mem <= '0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr[PTR_W-1:0]] <= push_tag;
            wr_ptr                     <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Testbench for aes_stream_arbiter. Request beats are queued per requester
// as they are presented, response beats as they are presented by the
// controller model, together with the expected grant order and response
// routing; a negedge monitor pops and compares on every handshake.

module tb_aes_stream_arbiter;

   localparam int DW = 32;
   localparam int TD = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              s0_tvalid, s0_tready, s0_tlast;
   logic [DW-1:0]     s0_tdata;
   logic              s1_tvalid, s1_tready, s1_tlast;
   logic [DW-1:0]     s1_tdata;
   logic              m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]     m_tdata;
   logic              r_tvalid, r_tready, r_tlast;
   logic [DW-1:0]     r_tdata;
   logic              d0_tvalid, d0_tready, d0_tlast;
   logic [DW-1:0]     d0_tdata;
   logic              d1_tvalid, d1_tready, d1_tlast;
   logic [DW-1:0]     d1_tdata;
   logic [1:0]        grant;
   logic [$clog2(TD):0] outstanding;

   always #5 clk = ~clk;

   aes_stream_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .resetn(resetn),
      .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
      .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tdata(r_tdata), .r_tlast(r_tlast),
      .d0_tvalid(d0_tvalid), .d0_tready(d0_tready), .d0_tdata(d0_tdata), .d0_tlast(d0_tlast),
      .d1_tvalid(d1_tvalid), .d1_tready(d1_tready), .d1_tdata(d1_tdata), .d1_tlast(d1_tlast),
      .grant(grant), .outstanding(outstanding)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard queues: {tlast, tdata} per beat, grant per request packet,
   // destination per response packet.
   logic [DW:0] q0[$];
   logic [DW:0] q1[$];
   logic [DW:0] rq[$];
   logic [1:0]  g_q[$];
   int          rt_q[$];

   int cyc     = 0;
   int last_tl = -1;
   bit gap_en  = 1'b0;
   bit in_req  = 1'b0;
   bit in_rsp  = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic req_beat();
      logic [DW:0] e;
      logic [1:0]  eg;
      if (!in_req) begin
         if (g_q.size() == 0) begin
            check("req_unexpected_pkt", grant, 2'b00);
         end else begin
            eg = g_q.pop_front();
            check("grant_seq", grant, eg);
            if (gap_en && last_tl >= 0) check("pkt_gap", cyc - last_tl, 2);
         end
      end
      if (grant == 2'b01 && q0.size() != 0) begin
         e = q0.pop_front();
         check("m_beat_s0", {m_tlast, m_tdata}, e);
      end else if (grant == 2'b10 && q1.size() != 0) begin
         e = q1.pop_front();
         check("m_beat_s1", {m_tlast, m_tdata}, e);
      end else begin
         check("m_beat_no_source", {grant, m_tdata}, 0);
      end
      in_req = !m_tlast;
      if (m_tlast) last_tl = cyc;
   endtask

   task automatic rsp_beat(input int dst, input logic [DW:0] obs);
      logic [DW:0] e;
      int          ed;
      if (!in_rsp) begin
         if (rt_q.size() == 0) begin
            check("rsp_unexpected_pkt", dst, 99);
         end else begin
            ed = rt_q.pop_front();
            check("rsp_route", dst, ed);
         end
      end
      if (rq.size() == 0) begin
         check("rsp_extra_beat", rq.size(), 1);
      end else begin
         e = rq.pop_front();
         check("rsp_beat", obs, e);
      end
      in_rsp = !obs[DW];
   endtask

   // Monitor: outputs are stable at the negedge; a handshake seen here
   // completes on the following posedge.
   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         in_req = 1'b0;
         in_rsp = 1'b0;
      end else begin
         if (grant == 2'b01) begin
            check("s1_blocked", s1_tready, 1'b0);
            check("s0_ready_mirror", s0_tready, m_tready);
         end
         if (grant == 2'b10) begin
            check("s0_blocked", s0_tready, 1'b0);
            check("s1_ready_mirror", s1_tready, m_tready);
         end
         if (grant == 2'b00) check("idle_m_tvalid", m_tvalid, 1'b0);
         if (m_tvalid && m_tready) req_beat();
         if (d0_tvalid && d0_tready) begin
            check("d1_quiet", d1_tvalid, 1'b0);
            rsp_beat(0, {d0_tlast, d0_tdata});
         end
         if (d1_tvalid && d1_tready) begin
            check("d0_quiet", d0_tvalid, 1'b0);
            rsp_beat(1, {d1_tlast, d1_tdata});
         end
      end
   end

   task automatic drive_s(input int src, input logic v, input logic [DW-1:0] d, input logic l);
      if (src == 0) begin
         s0_tvalid = v; s0_tdata = d; s0_tlast = l;
      end else begin
         s1_tvalid = v; s1_tdata = d; s1_tlast = l;
      end
   endtask

   // src 0/1: request streams, 2: controller response stream.
   task automatic wait_hs(input int src, output bit ok);
      int t;
      bit hs;
      t  = 0;
      ok = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) return;
         case (src)
            0:       hs = s0_tvalid && s0_tready;
            1:       hs = s1_tvalid && s1_tready;
            default: hs = r_tvalid && r_tready;
         endcase
         if (hs) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
         t++;
         if (t >= 400) begin
            check("handshake_timeout", t, 0);
            return;
         end
      end
   endtask

   task automatic send(input int src, input int n, input logic [DW-1:0] base, input bit hold);
      logic [DW-1:0] d;
      logic          l;
      bit            ok;
      for (int i = 0; i < n; i++) begin
         d = base + DW'(i);
         l = (i == n - 1);
         drive_s(src, 1'b1, d, l);
         if (src == 0) q0.push_back({l, d}); else q1.push_back({l, d});
         wait_hs(src, ok);
         if (!ok) begin
            drive_s(src, 1'b0, '0, 1'b0);
            return;
         end
      end
      if (!hold) drive_s(src, 1'b0, '0, 1'b0);
   endtask

   task automatic send_pkts(input int src, input int cnt, input int n, input logic [DW-1:0] base);
      for (int k = 0; k < cnt; k++) begin
         send(src, n, base + DW'(k * 16), k < cnt - 1);
      end
   endtask

   task automatic resp(input int n, input logic [DW-1:0] base);
      bit ok;
      for (int i = 0; i < n; i++) begin
         r_tvalid = 1'b1;
         r_tdata  = base + DW'(i);
         r_tlast  = (i == n - 1);
         rq.push_back({r_tlast, r_tdata});
         wait_hs(2, ok);
         if (!ok) break;
      end
      r_tvalid = 1'b0;
      r_tdata  = '0;
      r_tlast  = 1'b0;
   endtask

   task automatic flush_queues();
      q0.delete(); q1.delete(); rq.delete(); g_q.delete(); rt_q.delete();
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_q0_left"}, q0.size(), 0);
      check({tag, "_q1_left"}, q1.size(), 0);
      check({tag, "_rq_left"}, rq.size(), 0);
      check({tag, "_grant_left"}, g_q.size(), 0);
      check({tag, "_route_left"}, rt_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, grant, 2'b00);
      check({tag, "_outstanding"}, outstanding, 0);
      check({tag, "_m_tvalid"}, m_tvalid, 1'b0);
      check({tag, "_m_tdata"}, m_tdata, 0);
      check({tag, "_m_tlast"}, m_tlast, 1'b0);
      check({tag, "_s0_tready"}, s0_tready, 1'b0);
      check({tag, "_s1_tready"}, s1_tready, 1'b0);
      check({tag, "_r_tready"}, r_tready, 1'b0);
      check({tag, "_d0"}, {d0_tvalid, d0_tlast, d0_tdata}, 0);
      check({tag, "_d1"}, {d1_tvalid, d1_tlast, d1_tdata}, 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(2);
      flush_queues();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      // Reset with live-looking inputs: outputs must still be quiet.
      resetn    = 1'b0;
      m_tready  = 1'b1;
      d0_tready = 1'b1;
      d1_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 32'hA5A5_A5A5; s0_tlast = 1'b1;
      s1_tvalid = 1'b1; s1_tdata = 32'h5A5A_5A5A; s1_tlast = 1'b1;
      r_tvalid  = 1'b1; r_tdata  = 32'h1234_5678; r_tlast  = 1'b1;
      step(2);
      check_reset_outputs("rst");
      drive_s(0, 1'b0, '0, 1'b0);
      drive_s(1, 1'b0, '0, 1'b0);
      r_tvalid = 1'b0; r_tdata = '0; r_tlast = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Single packet from s0 and its response.
      g_q.push_back(2'b01);
      fork
         send(0, 6, 32'h0000_0100, 1'b0);
         begin
            @(negedge clk);
            check("arb_latency_grant", grant, 2'b00);
            check("arb_latency_m_tvalid", m_tvalid, 1'b0);
            @(negedge clk);
            check("first_grant", grant, 2'b01);
         end
      join
      step(2);
      check("single_grant_idle", grant, 2'b00);
      check("single_outstanding", outstanding, 1);
      rt_q.push_back(0);
      resp(4, 32'h0000_0200);
      step(1);
      check("single_outstanding_after", outstanding, 0);
      check_drained("single");

      // Contention: both continuously valid, 3-beat packets.
      do_reset();
      gap_en  = 1'b1;
      last_tl = -1;
`ifdef AES_ARB_ROUND_ROBIN_EN
      g_q.push_back(2'b01); g_q.push_back(2'b10); g_q.push_back(2'b01); g_q.push_back(2'b10);
`else
      g_q.push_back(2'b01); g_q.push_back(2'b01); g_q.push_back(2'b10); g_q.push_back(2'b10);
`endif
      fork
         send_pkts(0, 2, 3, 32'h0000_0300);
         send_pkts(1, 2, 3, 32'h0000_0400);
      join
      gap_en = 1'b0;
      step(1);
      check("contention_outstanding", outstanding, 4);
`ifdef AES_ARB_ROUND_ROBIN_EN
      rt_q.push_back(0); rt_q.push_back(1); rt_q.push_back(0); rt_q.push_back(1);
`else
      rt_q.push_back(0); rt_q.push_back(0); rt_q.push_back(1); rt_q.push_back(1);
`endif
      for (int k = 0; k < 4; k++) resp(2, 32'h0000_0500 + 32'(k * 16));
      step(1);
      check("contention_outstanding_after", outstanding, 0);
      check_drained("contention");

      // Full tag FIFO blocks new grants until a response pops a tag.
      for (int k = 0; k < 4; k++) begin
         g_q.push_back(2'b01);
         send(0, 2, 32'h0000_0600 + 32'(k * 16), 1'b0);
      end
      step(1);
      check("full_outstanding", outstanding, 4);
      g_q.push_back(2'b10);
      fork
         send(1, 2, 32'h0000_0700, 1'b0);
         begin
            repeat (8) begin
               @(negedge clk);
               check("full_no_grant", grant, 2'b00);
               check("full_s1_blocked", s1_tready, 1'b0);
            end
            @(posedge clk);
            #1;
            rt_q.push_back(0);
            resp(1, 32'h0000_0780);
         end
      join
      step(1);
      check("full_outstanding_resumed", outstanding, 4);
      rt_q.push_back(0); rt_q.push_back(0); rt_q.push_back(0); rt_q.push_back(1);
      for (int k = 0; k < 4; k++) resp(1, 32'h0000_0790 + 32'(k));
      step(1);
      check("full_outstanding_after", outstanding, 0);
      check_drained("full");

      // Ordering s1, s0, s1 with a stalled d0 on the second response.
      g_q.push_back(2'b10); g_q.push_back(2'b01); g_q.push_back(2'b10);
      send(1, 2, 32'h0000_0800, 1'b0);
      send(0, 2, 32'h0000_0810, 1'b0);
      send(1, 2, 32'h0000_0820, 1'b0);
      step(1);
      check("order_outstanding", outstanding, 3);
      rt_q.push_back(1); rt_q.push_back(0); rt_q.push_back(1);
      resp(2, 32'h0000_0900);
      d0_tready = 1'b0;
      fork
         resp(2, 32'h0000_0910);
         begin
            repeat (4) begin
               @(negedge clk);
               check("stall_r_tready", r_tready, 1'b0);
               check("stall_d0_tvalid", d0_tvalid, 1'b1);
            end
            @(posedge clk);
            #1;
            d0_tready = 1'b1;
         end
      join
      resp(2, 32'h0000_0920);
      step(1);
      check("order_outstanding_after", outstanding, 0);
      check_drained("order");

      // Backpressure: m_tready toggles mid-packet.
      g_q.push_back(2'b01);
      fork
         send(0, 6, 32'h0000_0A00, 1'b0);
         begin
            step(2);
            for (int i = 0; i < 8; i++) begin
               m_tready = (i % 2) != 0;
               step(1);
            end
            m_tready = 1'b1;
         end
      join
      rt_q.push_back(0);
      resp(1, 32'h0000_0A80);
      step(1);
      check("bp_outstanding_after", outstanding, 0);
      check_drained("backpressure");

      // Asynchronous reset during beat 3 of 6.
      g_q.push_back(2'b01);
      fork
         send(0, 6, 32'h0000_0B00, 1'b0);
         begin
            step(3);
            #2;
            resetn = 1'b0;
            #1;
            check_reset_outputs("midrst");
         end
      join
      flush_queues();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      g_q.push_back(2'b10);
      send(1, 3, 32'h0000_0C00, 1'b0);
      step(1);
      check("post_rst_outstanding", outstanding, 1);
      rt_q.push_back(1);
      resp(2, 32'h0000_0C80);
      step(1);
      check("post_rst_outstanding_after", outstanding, 0);
      check_drained("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
